ov_config_sequencer: RTL and testbench

Walks a camera register-configuration table (16-bit entries {reg_addr, reg_data}, combinational ROM) and issues each entry as a register write to the SCCB master over a valid/ready handshake. It is the parametrised successor of the fixed single-table config ROM and sits between the per-sensor config ROM and the SCCB write engine. It adds:
- multiple table profiles (e.g. UXGA/SVGA/CIF) selected at start;
- delay entries;
- bank tracking;
- bounded retry on NACK;
- status reporting.

---
 rtl/ov_config_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ov_config_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov_config_sequencer.sv
// Walks the selected profile's {reg_addr, reg_data} table and issues each entry as an SCCB write; first Wr_Valid 3 cycles after Start.
// Wr_Valid/Wr_Addr/Wr_Data hold until Wr_Ready; 0xFE entries stall the walk, NACKed writes retry up to MAX_RETRY times.
module ov_config_sequencer #(
    parameter int REG_ADDR_WIDTH = 8,
    parameter int REG_DATA_WIDTH = 8,
    parameter int INDEX_WIDTH    = 8,
    parameter int PROFILE_BITS   = 2,
    parameter int DELAY_UNIT     = 50000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic                                   Start,
    input  logic [PROFILE_BITS-1:0]                Profile,
    output logic [PROFILE_BITS+INDEX_WIDTH-1:0]    Rom_Addr,
    input  logic [REG_ADDR_WIDTH+REG_DATA_WIDTH-1:0] Rom_Data,
    output logic                                   Wr_Valid,
    input  logic                                   Wr_Ready,
    output logic [REG_ADDR_WIDTH-1:0]              Wr_Addr,
    output logic [REG_DATA_WIDTH-1:0]              Wr_Data,
    input  logic                                   Wr_Done,
    input  logic                                   Wr_Nack,
    output logic                                   Busy,
    output logic                                   Done,
    output logic                                   Error,
    output logic [REG_DATA_WIDTH-1:0]              Bank,
    output logic [INDEX_WIDTH-1:0]                 Count
);
    localparam int EW = REG_ADDR_WIDTH + REG_DATA_WIDTH;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_BANK  = '1;
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_DELAY = ADDR_BANK - 1'b1;
    localparam logic [REG_DATA_WIDTH-1:0] DATA_ONES  = '1;
    localparam logic [INDEX_WIDTH-1:0]    IDX_LAST   = '1;
    localparam logic [31:0]               DLY_UNIT   = 32'(DELAY_UNIT);
    localparam logic [RW-1:0]             RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RESP, S_WAIT_DLY, S_DONE, S_ERROR
    } state_t;

    state_t                    state_q, state_d;
    logic [PROFILE_BITS-1:0]   profile_q, profile_d;
    logic [INDEX_WIDTH-1:0]    index_q, index_d;
    logic [INDEX_WIDTH-1:0]    count_q, count_d;
    logic [EW-1:0]             entry_q, entry_d;
    logic [RW-1:0]             retry_q, retry_d;
    logic [31:0]               dly_q, dly_d;
    logic [REG_DATA_WIDTH-1:0] bank_q, bank_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic [REG_ADDR_WIDTH-1:0] ent_addr;
    logic [REG_DATA_WIDTH-1:0] ent_data;
    logic                      at_last;
    state_t                    adv_state;
    logic [INDEX_WIDTH-1:0]    adv_index;

    assign ent_addr = entry_q[EW-1:REG_DATA_WIDTH];
    assign ent_data = entry_q[REG_DATA_WIDTH-1:0];

    // The last index never wraps: once processed, the sequence ends with Rom_Addr parked on it.
    assign at_last   = (index_q == IDX_LAST);
    assign adv_state = at_last ? S_DONE : S_FETCH;
    assign adv_index = at_last ? index_q : index_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        profile_d = profile_q;
        index_d   = index_q;
        count_d   = count_q;
        entry_d   = entry_q;
        retry_d   = retry_q;
        dly_d     = dly_q;
        bank_d    = bank_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    profile_d = Profile;
                    index_d   = '0;
                    count_d   = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                entry_d = Rom_Data;
                retry_d = '0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ent_addr == ADDR_BANK && ent_data == DATA_ONES) begin
                    state_d = S_DONE;
                end else if (ent_addr == ADDR_DELAY) begin
                    if (ent_data == '0) begin
                        index_d = adv_index;
                        state_d = adv_state;
                    end else begin
                        dly_d   = 32'(ent_data) * DLY_UNIT;
                        state_d = S_WAIT_DLY;
                    end
                end else begin
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Wr_Ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (Wr_Done) begin
                    if (!Wr_Nack) begin
                        if (count_q != IDX_LAST) count_d = count_q + 1'b1;
                        if (ent_addr == ADDR_BANK) bank_d = ent_data;
                        index_d = adv_index;
                        state_d = adv_state;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        valid_d = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_WAIT_DLY: begin
                dly_d = dly_q - 1'b1;
                if (dly_q <= 32'd1) begin
                    index_d = adv_index;
                    state_d = adv_state;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                busy_d  = 1'b0;
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            profile_q <= '0;
            index_q   <= '0;
            count_q   <= '0;
            entry_q   <= '0;
            retry_q   <= '0;
            dly_q     <= '0;
            bank_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            profile_q <= profile_d;
            index_q   <= index_d;
            count_q   <= count_d;
            entry_q   <= entry_d;
            retry_q   <= retry_d;
            dly_q     <= dly_d;
            bank_q    <= bank_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign Rom_Addr = {profile_q, index_q};
    assign Wr_Valid = valid_q;
    assign Wr_Addr  = ent_addr;
    assign Wr_Data  = ent_data;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Error    = error_q;
    assign Bank     = bank_q;
    assign Count    = count_q;
endmodule

// File: tb/tb_ov_config_sequencer.sv
// Bench for ov_config_sequencer: ROM model, SCCB responder with programmable Ready stall and NACK, table-driven sequences plus reset/wrap cases.
module tb_ov_config_sequencer;
    logic        Clk, Reset, Start;
    logic [1:0]  Profile;
    logic [9:0]  Rom_Addr;
    logic [15:0] Rom_Data;
    logic        Wr_Valid, Wr_Ready, Wr_Done, Wr_Nack;
    logic [7:0]  Wr_Addr, Wr_Data, Bank, Count;
    logic        Busy, Done, Error;

    logic [15:0] rom [1024];
    assign Rom_Data = rom[Rom_Addr];

    ov_config_sequencer #(.DELAY_UNIT(10), .MAX_RETRY(3)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Profile(Profile),
        .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data),
        .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Wr_Done(Wr_Done), .Wr_Nack(Wr_Nack),
        .Busy(Busy), .Done(Done), .Error(Error), .Bank(Bank), .Count(Count)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SCCB responder: Ready rises after ready_hold cycles of Valid, Done pulses 4 cycles after accept.
    int          ready_hold = 0;
    bit          nack_all = 0;
    int          done_cnt = 0;
    int          low_cnt = 0;
    logic [15:0] wlog [$];

    initial begin
        Wr_Ready = 0; Wr_Done = 0; Wr_Nack = 0;
        forever begin
            @(negedge Clk);
            Wr_Done = 0; Wr_Nack = 0;
            if (Reset) begin
                done_cnt = 0; low_cnt = 0; Wr_Ready = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        Wr_Done = 1; Wr_Nack = nack_all;
                    end
                end
                if (!Wr_Valid) begin
                    Wr_Ready = 0; low_cnt = 0;
                end else if (!Wr_Ready) begin
                    if (low_cnt >= ready_hold) Wr_Ready = 1;
                    else low_cnt++;
                end
                if (Wr_Valid && Wr_Ready) begin
                    wlog.push_back({Wr_Addr, Wr_Data});
                    done_cnt = 4; low_cnt = 0;
                end
            end
        end
    end

    // Per-address occupancy while Busy; any Valid cycle must present the ROM entry at Rom_Addr.
    int addr_cyc [1024];
    int addr_vld [1024];
    int vld_bad = 0;

    initial begin
        forever begin
            @(negedge Clk);
            if (Busy === 1'b1) begin
                addr_cyc[Rom_Addr]++;
                if (Wr_Valid) begin
                    addr_vld[Rom_Addr]++;
                    if ({Wr_Addr, Wr_Data} !== rom[Rom_Addr]) vld_bad++;
                end
            end
        end
    end

    task automatic start_pulse(input logic [1:0] prof);
        for (int i = 0; i < 1024; i++) begin
            addr_cyc[i] = 0; addr_vld[i] = 0;
        end
        vld_bad = 0;
        wlog.delete();
        Profile = prof; Start = 1;
        @(negedge Clk);
        Start = 0; Profile = 2'd0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (Busy && cyc < 3000) begin
            @(negedge Clk);
            cyc++;
        end
        check({name, " finishes"}, 64'(cyc < 3000), 64'd1);
    endtask

    task automatic run_seq(input logic [1:0] prof, input string name);
        start_pulse(prof);
        wait_idle(name);
    endtask

    task automatic check_reset_zero(input string name);
        check(name, {Busy, Done, Error, Wr_Valid, Rom_Addr, Wr_Addr, Wr_Data, Bank, Count}, 64'd0);
    endtask

    typedef struct {
        logic [1:0]       profile;
        int               hold;
        bit               nack;
        int               nwr;
        logic [0:5][15:0] wr;
        logic [7:0]       bank;
        logic [7:0]       count;
        bit               done;
        bit               err;
        logic [9:0]       rom_addr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{2'd0, 0,  1'b0, 4, {16'hFF00, 16'h2CFF, 16'hFF01, 16'h1201, 16'h0, 16'h0}, 8'h01, 8'd4, 1'b1, 1'b0, 10'h004};
        vecs[1] = '{2'd2, 0,  1'b0, 3, {16'h3A11, 16'h3B22, 16'h3C33, 16'h0, 16'h0, 16'h0},   8'h01, 8'd3, 1'b1, 1'b0, 10'h205};
        vecs[2] = '{2'd1, 20, 1'b0, 1, {16'h4455, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},         8'h01, 8'd1, 1'b1, 1'b0, 10'h101};
        vecs[3] = '{2'd1, 0,  1'b1, 4, {16'h4455, 16'h4455, 16'h4455, 16'h4455, 16'h0, 16'h0}, 8'h01, 8'd0, 1'b0, 1'b1, 10'h100};
        vecs[4] = '{2'd3, 0,  1'b0, 2, {16'h5566, 16'hFFAA, 16'h0, 16'h0, 16'h0, 16'h0},      8'hAA, 8'd2, 1'b1, 1'b0, 10'h303};
        vecs[5] = '{2'd0, 0,  1'b0, 4, {16'hFF00, 16'h2CFF, 16'hFF01, 16'h1201, 16'h0, 16'h0}, 8'h01, 8'd4, 1'b1, 1'b0, 10'h004};

        for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
        rom[10'h000] = 16'hFF00; rom[10'h001] = 16'h2CFF; rom[10'h002] = 16'hFF01;
        rom[10'h003] = 16'h1201; rom[10'h004] = 16'hFFFF;
        rom[10'h100] = 16'h4455; rom[10'h101] = 16'hFFFF;
        rom[10'h200] = 16'h3A11; rom[10'h201] = 16'hFE03; rom[10'h202] = 16'h3B22;
        rom[10'h203] = 16'hFE00; rom[10'h204] = 16'h3C33; rom[10'h205] = 16'hFFFF;
        rom[10'h300] = 16'hFE05; rom[10'h301] = 16'h5566; rom[10'h302] = 16'hFFAA;
        rom[10'h303] = 16'hFFFF;

        Clk = 0; Reset = 1; Start = 0; Profile = 2'd0;
        repeat (3) @(negedge Clk);
        check_reset_zero("reset state");
        Reset = 0;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            ready_hold = vecs[i].hold;
            nack_all   = vecs[i].nack;
            run_seq(vecs[i].profile, $sformatf("v%0d", i));
            check($sformatf("v%0d write count", i), 64'(wlog.size()), 64'(vecs[i].nwr));
            for (int k = 0; k < vecs[i].nwr && k < wlog.size(); k++)
                check($sformatf("v%0d write %0d", i, k), 64'(wlog[k]), 64'(vecs[i].wr[k]));
            check($sformatf("v%0d Bank", i), 64'(Bank), 64'(vecs[i].bank));
            check($sformatf("v%0d Count", i), 64'(Count), 64'(vecs[i].count));
            check($sformatf("v%0d Done", i), 64'(Done), 64'(vecs[i].done));
            check($sformatf("v%0d Error", i), 64'(Error), 64'(vecs[i].err));
            check($sformatf("v%0d Busy", i), 64'(Busy), 64'd0);
            check($sformatf("v%0d Rom_Addr", i), 64'(Rom_Addr), 64'(vecs[i].rom_addr));
            check($sformatf("v%0d valid payload", i), 64'(vld_bad), 64'd0);
            if (i == 1) begin
                // FE03: FETCH + DECODE + 3*10 wait cycles; FE00: FETCH + DECODE only.
                check("profile 2 never reads profile 0", 64'(addr_cyc[10'h000]), 64'd0);
                check("FE03 dwell", 64'(addr_cyc[10'h201]), 64'd32);
                check("FE03 no valid", 64'(addr_vld[10'h201]), 64'd0);
                check("FE00 dwell", 64'(addr_cyc[10'h203]), 64'd2);
            end
            if (i == 2) check("valid held across stall", 64'(addr_vld[10'h100]), 64'd21);
        end

        // Start while busy is ignored.
        ready_hold = 0; nack_all = 0;
        start_pulse(2'd0);
        repeat (5) @(negedge Clk);
        Profile = 2'd2; Start = 1;
        @(negedge Clk);
        Start = 0; Profile = 2'd0;
        wait_idle("busy start");
        check("busy start write count", 64'(wlog.size()), 64'd4);
        check("busy start Rom_Addr", 64'(Rom_Addr), 64'h004);

        // Reset during WAIT_DLY.
        start_pulse(2'd3);
        repeat (10) @(negedge Clk);
        check("in delay Rom_Addr", 64'(Rom_Addr), 64'h300);
        #2 Reset = 1;
        #1 check_reset_zero("reset in delay");
        @(negedge Clk);
        Reset = 0;
        @(negedge Clk);
        run_seq(2'd0, "rerun after delay reset");
        check("rerun 1 write count", 64'(wlog.size()), 64'd4);
        if (wlog.size() > 0) check("rerun 1 first write", 64'(wlog[0]), 64'hFF00);
        check("rerun 1 Count", 64'(Count), 64'd4);

        // Reset during ISSUE with Ready stalled.
        ready_hold = 10;
        start_pulse(2'd0);
        for (int c = 0; c < 20 && !Wr_Valid; c++) @(negedge Clk);
        check("issue reached", 64'(Wr_Valid), 64'd1);
        #2 Reset = 1;
        #1 check_reset_zero("reset in issue");
        @(negedge Clk);
        Reset = 0; ready_hold = 0;
        @(negedge Clk);
        run_seq(2'd0, "rerun after issue reset");
        check("rerun 2 write count", 64'(wlog.size()), 64'd4);
        if (wlog.size() > 0) check("rerun 2 first write", 64'(wlog[0]), 64'hFF00);
        check("rerun 2 Done", 64'(Done), 64'd1);

        // Index runs to the last entry without END: that entry is written, then the sequence ends.
        for (int i = 10'h100; i < 10'h1FF; i++) rom[i] = 16'hFE00;
        rom[10'h1FF] = 16'h7788;
        run_seq(2'd1, "wrap");
        check("wrap write count", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) check("wrap write", 64'(wlog[0]), 64'h7788);
        check("wrap Count", 64'(Count), 64'd1);
        check("wrap Done", 64'(Done), 64'd1);
        check("wrap Rom_Addr", 64'(Rom_Addr), 64'h1FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
